// File: rtl/ct_ifu_icache_tag_pkg.sv
// Shared types and geometry constants for the I-cache tag array sequencer.
package ct_ifu_icache_tag_pkg;

   localparam int unsigned TAG_SETS = 512;
   localparam int unsigned SET_LSB  = 5;
   localparam int unsigned SET_MSB  = 13;
   localparam int unsigned WAY_W    = 29;
   localparam int unsigned DIN_W    = 59;
   localparam int unsigned IDX_W    = 16;
   localparam int unsigned CNT_W    = $clog2(TAG_SETS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      INV  = 2'd1,
      DONE = 2'd2
   } tag_state_e;

   // Place a set number into its field of the array address; other bits are zero.
   function automatic logic [IDX_W-1:0] set_to_index(input logic [CNT_W-1:0] set);
      logic [IDX_W-1:0] idx;
      idx                  = '0;
      idx[SET_MSB:SET_LSB] = set;
      return idx;
   endfunction

endpackage

// File: rtl/ct_ifu_icache_tag_seq.sv
// I-cache tag array access sequencer: invalidate-all sweep, refill writes and fetch reads
// share one array port with fixed priority sweep > refill > fetch.
module ct_ifu_icache_tag_seq
   import ct_ifu_icache_tag_pkg::*;
(
   input  logic                forever_cpuclk,
   input  logic                cpurst_b,
   input  logic                ifu_tag_inv_start,
   output logic                ifu_tag_inv_busy,
   output logic                ifu_tag_inv_done,
   input  logic                refill_tag_req,
   input  logic                refill_tag_way,
   input  logic [IDX_W-1:0]    refill_tag_index,
   input  logic [WAY_W-1:0]    refill_tag_data,
   input  logic                refill_tag_lru,
   output logic                refill_tag_grant,
   input  logic                fetch_tag_req,
   input  logic [IDX_W-1:0]    fetch_tag_index,
   output logic                fetch_tag_grant,
   output logic                fetch_tag_dout_vld,
   output logic [IDX_W-1:0]    ifu_icache_index,
   output logic                ifu_icache_tag_cen_b,
   output logic                ifu_icache_tag_clk_en,
   output logic [DIN_W-1:0]    ifu_icache_tag_din,
   output logic [2:0]          ifu_icache_tag_wen
);

   tag_state_e        r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
   logic              r_dout_vld;

   logic              w_refill_grant;
   logic              w_fetch_grant;
   logic [IDX_W-1:0]  w_index;
   logic              w_cen_b;
   logic [DIN_W-1:0]  w_din;
   logic [2:0]        w_wen;

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_dout_vld <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_dout_vld <= w_fetch_grant;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_refill_grant = 1'b0;
      w_fetch_grant  = 1'b0;
      w_index        = '0;
      w_cen_b        = 1'b1;
      w_din          = '0;
      w_wen          = 3'b111;

      unique case (r_state)
         INV: begin
            w_index   = set_to_index(r_cnt);
            w_cen_b   = 1'b0;
            w_wen     = 3'b000;
            // Natural 9-bit wrap leaves the counter at 0 for the next sweep.
            w_cnt_nxt = r_cnt + 1'b1;
            if (r_cnt == CNT_W'(TAG_SETS - 1)) begin
               w_state_nxt = DONE;
            end
         end
         IDLE, DONE: begin
            if (r_state == IDLE && ifu_tag_inv_start) begin
               w_state_nxt = INV;
            end else if (r_state == DONE) begin
               w_state_nxt = IDLE;
            end
            if (refill_tag_req) begin
               w_refill_grant         = 1'b1;
               w_index                = refill_tag_index;
               w_cen_b                = 1'b0;
               w_din[DIN_W-1]         = refill_tag_lru;
               if (refill_tag_way) begin
                  w_wen                      = 3'b001;
                  w_din[2*WAY_W-1:WAY_W]     = refill_tag_data;
               end else begin
                  w_wen                      = 3'b010;
                  w_din[WAY_W-1:0]           = refill_tag_data;
               end
            end else if (fetch_tag_req) begin
               w_fetch_grant = 1'b1;
               w_index       = fetch_tag_index;
               w_cen_b       = 1'b0;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign ifu_tag_inv_busy      = (r_state == INV);
   assign ifu_tag_inv_done      = (r_state == DONE);
   assign refill_tag_grant      = w_refill_grant;
   assign fetch_tag_grant       = w_fetch_grant;
   assign fetch_tag_dout_vld    = r_dout_vld;
   assign ifu_icache_index      = w_index;
   assign ifu_icache_tag_cen_b  = w_cen_b;
   assign ifu_icache_tag_clk_en = ~w_cen_b;
   assign ifu_icache_tag_din    = w_din;
   assign ifu_icache_tag_wen    = w_wen;

endmodule
